// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME sequencing, fixed-priority
// dispatch handshake with the control unit and the PC vector load.
module gb_cpu_interrupt_ctrl #(
   parameter int         NUM_INT    = 5,
   parameter logic [7:0] VEC_BASE   = 8'h40,
   parameter logic [7:0] VEC_STRIDE = 8'h08
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_INT-1:0] int_req,
   input  logic               if_wr_en,
   input  logic               ie_wr_en,
   input  logic [7:0]         wr_data,
   output logic [7:0]         if_q,
   output logic [7:0]         ie_q,
   input  logic               ei,
   input  logic               di,
   input  logic               reti,
   input  logic               instr_boundary,
   output logic               dispatch_req,
   input  logic               dispatch_ack,
   output logic               write_interrupt_vector,
   output logic [7:0]         interrupt_vector,
   output logic               ime,
   output logic               wake
);

   typedef enum logic [1:0] {IME_OFF, IME_ARMED, IME_ON} ime_state_t;
   typedef enum logic [1:0] {IDLE, PENDING, VECTOR} disp_state_t;

   ime_state_t         ime_state;
   disp_state_t        disp_state;
   logic [NUM_INT-1:0] if_reg;
   logic [7:0]         ie_reg;
   logic [NUM_INT-1:0] pending;
   logic [NUM_INT-1:0] sel_mask;
   logic [7:0]         sel_vec;
   logic               sel_valid;
   logic               ack_take;
   logic [NUM_INT-1:0] clr_mask;
   logic               eff_en;

   assign pending = ie_reg[NUM_INT-1:0] & if_reg;
   assign wake    = |pending;
   assign if_q    = {{(8-NUM_INT){1'b1}}, if_reg};
   assign ie_q    = ie_reg;
   assign ime     = (ime_state == IME_ON);
   assign ack_take = (disp_state == PENDING) && dispatch_ack;
   assign clr_mask = ack_take ? sel_mask : '0;
   // ARMED here was set by an earlier EI, so the instruction after EI is checked as enabled.
   assign eff_en  = (ime_state == IME_ON) || (ime_state == IME_ARMED);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel_valid = 1'b0;
      sel_mask  = '0;
      sel_vec   = 8'h00;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_valid   = 1'b1;
            sel_mask    = '0;
            sel_mask[i] = 1'b1;
            sel_vec     = VEC_BASE + VEC_STRIDE * 8'(i);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_reg <= '0;
         ie_reg <= 8'h00;
      end else begin
         if_reg <= ((if_wr_en ? wr_data[NUM_INT-1:0] : if_reg) & ~clr_mask) | int_req;
         if (ie_wr_en) ie_reg <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ime_state <= IME_OFF;
      end else if (di || dispatch_ack) begin
         ime_state <= IME_OFF;
      end else if (reti) begin
         ime_state <= IME_ON;
      end else if (ei && ime_state == IME_OFF) begin
         ime_state <= IME_ARMED;
      end else if (instr_boundary && ime_state == IME_ARMED) begin
         ime_state <= IME_ON;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_state             <= IDLE;
         dispatch_req           <= 1'b0;
         write_interrupt_vector <= 1'b0;
         interrupt_vector       <= 8'h00;
      end else begin
         case (disp_state)
            IDLE: begin
               if (instr_boundary && eff_en && (|pending)) begin
                  disp_state   <= PENDING;
                  dispatch_req <= 1'b1;
               end
            end
            PENDING: begin
               if (dispatch_ack) begin
                  disp_state             <= VECTOR;
                  dispatch_req           <= 1'b0;
                  write_interrupt_vector <= 1'b1;
                  // A request withdrawn before ack vectors to 0x0000.
                  interrupt_vector       <= sel_valid ? sel_vec : 8'h00;
               end
            end
            VECTOR: begin
               disp_state             <= IDLE;
               write_interrupt_vector <= 1'b0;
            end
            default: begin
               disp_state             <= IDLE;
               dispatch_req           <= 1'b0;
               write_interrupt_vector <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
Name: gb_cpu_interrupt_ctrl

Overview:
Interrupt controller for the Game Boy CPU, directly upstream of the register file. It holds the IF and IE registers and the master enable (IME), and arbitrates pending interrupts by fixed priority. It hands the control unit a dispatch request and drives the register file's write_interrupt_vector and interrupt_vector inputs for the PC load. It also provides the HALT wake-up condition.

Parameters:
NUM_INT, 5, number of interrupt sources; bit 0 = VBlank, then STAT, Timer, Serial, Joypad.
VEC_BASE, 8'h40, vector for bit 0.
VEC_STRIDE, 8'h08, vector spacing; vector for bit n = VEC_BASE + n*VEC_STRIDE.

Ports:
clk  in  1  machine clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
int_req  in  NUM_INT  one-cycle request pulses from peripherals
if_wr_en  in  1  bus write to FF0F
ie_wr_en  in  1  bus write to FFFF
wr_data  in  8  bus write data
if_q  out  8  IF readback: {3'b111, IF[4:0]}
ie_q  out  8  IE readback; all 8 bits stored
ei  in  1  EI executing; pulse coincides with EI's instr_boundary
di  in  1  DI executing
reti  in  1  RETI executing
instr_boundary  in  1  final M-cycle of the current instruction; interrupt check point
dispatch_req  out  1  request the control unit to run the ISR sequence
dispatch_ack  in  1  control unit is at the ISR M-cycle that loads PC
write_interrupt_vector  out  1  one-cycle PC-load strobe to the register file
interrupt_vector  out  8  vector low byte to the register file
ime  out  1  current IME state (IME_ON)
wake  out  1  combinational: |(IE[4:0] & IF[4:0]), independent of IME

Behaviour:
Reset values:
- IF=0, IE=0, IME FSM=IME_OFF, dispatch FSM=IDLE.
- dispatch_req=0, write_interrupt_vector=0, interrupt_vector=8'h00.
- Reset mid-dispatch returns to IDLE with no vector strobe.

IF update, priority high to low:
- IF_next = ((if_wr_en ? wr_data[4:0] : IF) & ~clr_mask) | int_req.
- Peripheral set wins over a same-cycle bus write and over a dispatch clear.
- IE_next = ie_wr_en ? wr_data : IE.

IME FSM (states IME_OFF, IME_ARMED, IME_ON):
- di (any state) -> IME_OFF; di beats ei/reti in the same cycle.
- reti -> IME_ON in the next cycle.
- ei in IME_OFF -> IME_ARMED. ei in IME_ARMED or IME_ON: no change.
- IME_ARMED + instr_boundary -> IME_ON. This boundary counts as enabled for the dispatch check, so EI;NOP services after the NOP.
- dispatch_ack -> IME_OFF.
- ime output is 1 only in IME_ON.

Dispatch FSM (states IDLE, PENDING, VECTOR):
- Pending mask P = IE[4:0] & IF[4:0].
- IDLE: on instr_boundary with an effective enable (IME_ON, or IME_ARMED not set by this cycle's ei) and P != 0 -> PENDING. dispatch_req is registered and goes high the next cycle.
- PENDING: dispatch_req held high. instr_boundary, ei and reti are ignored for dispatch. On dispatch_ack -> VECTOR. In that same cycle:
  - Re-evaluate P and select the lowest set bit n.
  - Latch interrupt_vector = VEC_BASE + n*VEC_STRIDE.
  - Set clr_mask = 1<<n and set IME_OFF.
- Cancelled dispatch: if P == 0 at ack (IE or IF changed), latch interrupt_vector = 8'h00 and clear no IF bit; the PC is loaded to 0x0000.
- VECTOR: write_interrupt_vector=1 and dispatch_req=0 for exactly one cycle, then -> IDLE. interrupt_vector holds its value until the next ack.
- Vector width: 8 bits; with the defaults the maximum is 8'h60, so there is no overflow.

Latency:
- instr_boundary -> dispatch_req: 1 cycle.
- dispatch_ack -> write_interrupt_vector: 1 cycle.

wake: asserted whenever P != 0, even with IME off, for HALT exit.

Test Plan:
- Reset, then IE=8'h1F, reti, int_req=5'b00100, instr_boundary -> dispatch_req=1 next cycle; ack -> next cycle write_interrupt_vector=1, interrupt_vector=8'h50, if_q=8'hE0, ime=0.
- IE=8'h1F, IF=5'b10010, IME_ON, boundary + ack -> interrupt_vector=8'h48; if_q=8'hF0; a second dispatch after reti yields 8'h60.
- EI timing: IF=1, IE=1, IME_OFF; ei with boundary -> no dispatch_req; next instr_boundary -> dispatch_req=1, vector 8'h40.
- Cancel: in PENDING, write IE=0 before ack -> interrupt_vector=8'h00, if_q unchanged, IME_OFF.
- Collisions: if_wr_en with wr_data=0 and int_req[3] in the same cycle -> if_q=8'hE8; int_req[0] on the ack cycle for bit 0 -> IF[0] stays 1.
- HALT/reset: IME_OFF, IE=4, int_req[2] -> wake=1, dispatch_req=0; reset asserted in PENDING -> all outputs 0, if_q=8'hE0.
